// File: rtl/fighter_sprite_renderer.sv
// Registered per-player fighter sprite: stick figure, hurtbox outline and state-coloured hitbox.
// Optional hit-flash counter and white figure are built when SPRITE_FLASH_EN is defined.
module fighter_sprite_renderer #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned HEIGHT       = 240,
    parameter int unsigned BORDER       = 2,
    parameter int unsigned HIT_W        = 32,
    parameter int unsigned HIT_Y0       = 80,
    parameter int unsigned HIT_H        = 80,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_tick,
    input  logic       frame_start,
    input  logic       video_on,
    input  logic [9:0] hcnt,
    input  logic [9:0] vcnt,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic       facing_left,
    input  logic       attacking,
    input  logic [2:0] state,
    input  logic       switch,
    input  logic       hit_taken,
    output logic       sprite_on,
    output logic       hitbox_on,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    localparam int unsigned CW = 11;
    typedef logic [CW-1:0] coord_t;

    localparam coord_t W_C   = coord_t'(WIDTH);
    localparam coord_t H_C   = coord_t'(HEIGHT);
    localparam coord_t B_C   = coord_t'(BORDER);
    localparam coord_t HW_C  = coord_t'(HIT_W);
    localparam coord_t HY0_C = coord_t'(HIT_Y0);
    localparam coord_t HH_C  = coord_t'(HIT_H);
    localparam coord_t CX_C  = coord_t'(WIDTH / 2);

    // Pose shadow, loaded once per frame so geometry never tears mid-frame
    logic [9:0] sx, sy;
    logic       sface, satk;
    logic [2:0] sstate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx     <= '0;
            sy     <= '0;
            sface  <= 1'b0;
            satk   <= 1'b0;
            sstate <= '0;
        end else if (pix_tick && frame_start) begin
            sx     <= x_pos;
            sy     <= y_pos;
            sface  <= facing_left;
            satk   <= attacking;
            sstate <= state;
        end
    end

    logic flash_white;

`ifdef SPRITE_FLASH_EN
    logic [7:0] flash_cnt;

    // A new hit always restarts the flash, even on a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
        end else if (pix_tick) begin
            if (hit_taken) begin
                flash_cnt <= 8'(FLASH_FRAMES);
            end else if (frame_start && (flash_cnt != 8'd0)) begin
                flash_cnt <= flash_cnt - 8'd1;
            end
        end
    end

    assign flash_white = (flash_cnt != 8'd0) && flash_cnt[0];
`else
    logic unused_flash;
    assign unused_flash = &{1'b0, hit_taken, 8'(FLASH_FRAMES)};
    assign flash_white  = 1'b0;
`endif

    coord_t h, v, x, y;
    assign h = {1'b0, hcnt};
    assign v = {1'b0, vcnt};
    assign x = {1'b0, sx};
    assign y = {1'b0, sy};

    logic in_hurt, outline, in_hit_v, in_hit_h;
    assign in_hurt  = (h >= x) && (h < x + W_C) && (v >= y) && (v < y + H_C);
    assign outline  = in_hurt && ((h < x + B_C) || (h >= x + W_C - B_C) ||
                                  (v < y + B_C) || (v >= y + H_C - B_C));
    assign in_hit_v = (v >= y + HY0_C) && (v < y + HY0_C + HH_C);
    // Left-facing span written as h+HIT_W >= x so it clips at column 0
    assign in_hit_h = sface ? ((h + HW_C >= x) && (h < x))
                            : ((h >= x + W_C) && (h < x + W_C + HW_C));

    // Figure in sprite-relative coordinates, mirrored about the centre column
    coord_t rx, ry, mx, dx, dyh, ra, rl;
    assign rx  = h - x;
    assign ry  = v - y;
    assign mx  = sface ? (W_C - rx) : rx;
    assign dx  = (mx >= CX_C) ? (mx - CX_C) : (CX_C - mx);
    assign dyh = (ry >= 11'd40) ? (ry - 11'd40) : (11'd40 - ry);
    assign ra  = ry - 11'd80;
    assign rl  = ry - 11'd120;

    logic [22:0] head_d;
    logic [11:0] dx2;
    logic [12:0] dx3;
    assign head_d = 23'(dx) * 23'(dx) + 23'(dyh) * 23'(dyh);
    assign dx2    = {dx, 1'b0};
    assign dx3    = 13'(dx) * 13'd3;

    logic head, body, arm, leg, figure;
    assign head   = head_d < 23'd400;
    assign body   = (dx <= 11'd2) && (ry >= 11'd60) && (ry <= 11'd120);
    assign arm    = (ry >= 11'd80) && (ry <= 11'd120) &&
                    (dx2 >= 12'(ra)) && (dx2 < 12'(ra) + 12'd8);
    assign leg    = (ry >= 11'd120) && (ry <= 11'd180) &&
                    (dx3 >= 13'(rl)) && (dx3 < 13'(rl) + 13'd12);
    assign figure = in_hurt && (head || body || arm || leg);

    logic hit_draw, out_draw;
    assign hit_draw = satk && in_hit_v && in_hit_h;
    assign out_draw = switch && outline;

    logic        on_nxt, hit_nxt;
    logic [11:0] rgb_nxt;

    // Colour priority: hitbox, then outline, then figure
    always_comb begin
        on_nxt  = 1'b0;
        hit_nxt = 1'b0;
        rgb_nxt = 12'h000;
        if (video_on) begin
            on_nxt  = hit_draw || out_draw || figure;
            hit_nxt = hit_draw;
            if (hit_draw) begin
                case (sstate)
                    3'd5:    rgb_nxt = 12'h00F;
                    3'd6:    rgb_nxt = 12'hF80;
                    default: rgb_nxt = 12'h0F0;
                endcase
            end else if (out_draw) begin
                rgb_nxt = 12'hF00;
            end else if (figure) begin
                rgb_nxt = flash_white ? 12'hFFF : 12'h00F;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprite_on <= 1'b0;
            hitbox_on <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else if (pix_tick) begin
            sprite_on <= on_nxt;
            hitbox_on <= hit_nxt;
            {r, g, b} <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_fighter_sprite_renderer.sv
// Bench for fighter_sprite_renderer: pixel-rule reference model compared every cycle,
// plus literal expectations for the directed scenarios. Honours SPRITE_FLASH_EN.
module tb_fighter_sprite_renderer;

    localparam int W = 64, H = 240, B = 2, HW = 32, HY0 = 80, HH = 80, FF = 3;

    localparam logic [13:0] BLANK      = 14'h0000;
    localparam logic [13:0] FIG_BLUE   = 14'h200F;
    localparam logic [13:0] FIG_WHITE  = 14'h2FFF;
    localparam logic [13:0] OUT_RED    = 14'h2F00;
    localparam logic [13:0] HIT_ORANGE = 14'h3F80;
    localparam logic [13:0] HIT_GREEN  = 14'h30F0;
    localparam logic [13:0] HIT_BLUE   = 14'h300F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pix_tick, frame_start, video_on, facing_left, attacking, sw, hit_taken;
    logic [9:0] hcnt, vcnt, x_pos, y_pos;
    logic [2:0] state;
    logic       sprite_on, hitbox_on;
    logic [3:0] r, g, b;

    fighter_sprite_renderer #(
        .WIDTH(W), .HEIGHT(H), .BORDER(B), .HIT_W(HW), .HIT_Y0(HY0), .HIT_H(HH),
        .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .frame_start(frame_start),
        .video_on(video_on), .hcnt(hcnt), .vcnt(vcnt), .x_pos(x_pos), .y_pos(y_pos),
        .facing_left(facing_left), .attacking(attacking), .state(state), .switch(sw),
        .hit_taken(hit_taken), .sprite_on(sprite_on), .hitbox_on(hitbox_on),
        .r(r), .g(g), .b(b)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference state: latched pose, flash count, expected registered outputs
    int          m_x, m_y, m_face, m_atk, m_state, m_cnt;
    logic        e_on, e_hit;
    logic [11:0] e_rgb;

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_face = 0; m_atk = 0; m_state = 0; m_cnt = 0;
        e_on = 1'b0; e_hit = 1'b0; e_rgb = 12'h000;
    endfunction

    function automatic void predict();
        int  hh, vv, rx, ry, mx, dxs, dx;
        bit  in_hurt, head, body, arm, leg, fig, outl, hitd, outd, white;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!pix_tick) return;
        hh = int'(hcnt);
        vv = int'(vcnt);
        rx = hh - m_x;
        ry = vv - m_y;
        in_hurt = hh >= m_x && hh < m_x + W && vv >= m_y && vv < m_y + H;
        mx   = (m_face != 0) ? W - rx : rx;
        dxs  = mx - W / 2;
        dx   = (dxs < 0) ? -dxs : dxs;
        head = dxs * dxs + (ry - 40) * (ry - 40) < 400;
        body = dx <= 2 && ry >= 60 && ry <= 120;
        arm  = ry >= 80 && ry <= 120 && 2 * dx >= ry - 80 && 2 * dx < ry - 72;
        leg  = ry >= 120 && ry <= 180 && 3 * dx >= ry - 120 && 3 * dx < ry - 108;
        fig  = in_hurt && (head || body || arm || leg);
        outl = in_hurt && (hh < m_x + B || hh >= m_x + W - B || vv < m_y + B || vv >= m_y + H - B);
        hitd = m_atk != 0 && vv >= m_y + HY0 && vv < m_y + HY0 + HH &&
               ((m_face != 0) ? (hh >= m_x - HW && hh < m_x) : (hh >= m_x + W && hh < m_x + W + HW));
        outd = sw && outl;
`ifdef SPRITE_FLASH_EN
        white = (m_cnt != 0) && (m_cnt % 2 == 1);
`else
        white = 1'b0;
`endif
        e_on  = video_on && (hitd || outd || fig);
        e_hit = video_on && hitd;
        e_rgb = 12'h000;
        if (video_on) begin
            if (hitd)      e_rgb = (m_state == 5) ? 12'h00F : (m_state == 6) ? 12'hF80 : 12'h0F0;
            else if (outd) e_rgb = 12'hF00;
            else if (fig)  e_rgb = white ? 12'hFFF : 12'h00F;
        end
        if (frame_start) begin
            m_x = int'(x_pos); m_y = int'(y_pos); m_face = int'(facing_left);
            m_atk = int'(attacking); m_state = int'(state);
        end
`ifdef SPRITE_FLASH_EN
        if (hit_taken) m_cnt = FF;
        else if (frame_start && m_cnt > 0) m_cnt = m_cnt - 1;
`endif
    endfunction

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            checks++;
            if ({sprite_on, hitbox_on, r, g, b} !== {e_on, e_hit, e_rgb}) begin
                failures++;
                $display("FAIL model_cmp t=%0t h=%0d v=%0d got on=%b hit=%b rgb=%h want on=%b hit=%b rgb=%h",
                         $time, hcnt, vcnt, sprite_on, hitbox_on, {r, g, b}, e_on, e_hit, e_rgb);
            end
        end
    end

    task automatic lit(input string name, input logic [13:0] want);
        checks++;
        if ({sprite_on, hitbox_on, r, g, b} !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, {sprite_on, hitbox_on, r, g, b}, want);
        end
    endtask

    task automatic drive(input logic p, input logic fs, input logic vo,
                         input int h, input int v, input logic ht);
        @(negedge clk);
        pix_tick = p; frame_start = fs; video_on = vo;
        hcnt = 10'(h); vcnt = 10'(v); hit_taken = ht;
        predict();
        @(posedge clk);
        #2;
    endtask

    task automatic new_frame(input int x, input int y, input logic f, input logic a, input int st);
        x_pos = 10'(x); y_pos = 10'(y); facing_left = f; attacking = a; state = 3'(st);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int hh, vv;
        rst_n = 1'b0; pix_tick = 1'b0; frame_start = 1'b0; video_on = 1'b0;
        hcnt = '0; vcnt = '0; x_pos = '0; y_pos = '0; facing_left = 1'b0;
        attacking = 1'b0; state = '0; sw = 1'b0; hit_taken = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 1'b1, 32, 40, 1'b0);
        lit("reset_outputs", BLANK);
        rst_n = 1'b1;

        // Pose is zero after reset until a frame_start
        drive(1'b1, 1'b0, 1'b1, 32, 40, 1'b0);
        lit("pose_zero_head", FIG_BLUE);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("pose_zero_blank", BLANK);

        // Pose latch and mid-frame input change
        new_frame(100, 50, 1'b0, 1'b0, 0);
        x_pos = 10'd300;
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("latched_head", FIG_BLUE);
        for (int vi = 50; vi < 290; vi += 40) begin
            drive(1'b1, 1'b0, 1'b1, 300, vi, 1'b0);
            lit("col300_blank", BLANK);
        end

        // Hitbox colours facing right
        new_frame(100, 50, 1'b0, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b1, 170, 170, 1'b0);
        lit("hit_state6", HIT_ORANGE);
        drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        lit("hold_no_tick", HIT_ORANGE);
        new_frame(100, 50, 1'b0, 1'b1, 5);
        drive(1'b1, 1'b0, 1'b1, 170, 170, 1'b0);
        lit("hit_state5", HIT_BLUE);

        // Outline with hitbox priority
        sw = 1'b1;
        new_frame(100, 50, 1'b0, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b1, 100, 100, 1'b0);
        lit("outline_red", OUT_RED);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("outline_fig", FIG_BLUE);
        drive(1'b1, 1'b0, 1'b1, 163, 150, 1'b0);
        lit("outline_edge", OUT_RED);
        drive(1'b1, 1'b0, 1'b1, 164, 150, 1'b0);
        lit("hit_over_outline", HIT_ORANGE);
        sw = 1'b0;

        // Facing left clipped at column 0
        new_frame(10, 50, 1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 1'b1, 0, 150, 1'b0);
        lit("left_h0", HIT_GREEN);
        drive(1'b1, 1'b0, 1'b1, 9, 150, 1'b0);
        lit("left_h9", HIT_GREEN);
        drive(1'b1, 1'b0, 1'b1, 10, 150, 1'b0);
        lit("left_h10", BLANK);
        drive(1'b1, 1'b0, 1'b1, 1000, 150, 1'b0);
        lit("left_h1000", BLANK);
        drive(1'b1, 1'b0, 1'b1, 1023, 150, 1'b0);
        lit("left_h1023", BLANK);

        // Mid-frame reset
        new_frame(100, 50, 1'b0, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b1, 170, 170, 1'b0);
        rst_n = 1'b0;
        #1;
        lit("midreset_async", BLANK);
        model_reset();
        drive(1'b1, 1'b0, 1'b1, 170, 170, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 170, 170, 1'b0);
        lit("midreset_pose0_blank", BLANK);
        drive(1'b1, 1'b0, 1'b1, 32, 40, 1'b0);
        lit("midreset_pose0_head", FIG_BLUE);

        // frame_start without pix_tick is ignored
        new_frame(100, 50, 1'b0, 1'b0, 0);
        x_pos = 10'd300;
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("fs_no_tick", FIG_BLUE);

        // Hit flash
        new_frame(100, 50, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
`ifdef SPRITE_FLASH_EN
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("flash_f0", FIG_WHITE);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("flash_f1", FIG_BLUE);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("flash_f2", FIG_WHITE);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("flash_done", FIG_BLUE);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("flash_reload_wins", FIG_WHITE);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("flash_reload_next", FIG_BLUE);
`else
        drive(1'b1, 1'b0, 1'b1, 132, 90, 1'b0);
        lit("noflash_blue", FIG_BLUE);
`endif

        // Randomised frames and pixels around the sprite
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                x_pos = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 40)) : 10'($urandom);
                y_pos = 10'($urandom);
                facing_left = 1'($urandom);
                attacking = ($urandom_range(0, 2) != 0);
                state = 3'($urandom);
                sw = 1'($urandom);
                drive(1'($urandom_range(0, 4) != 0), 1'b1, 1'b0, 0, 0,
                      $urandom_range(0, 5) == 0);
            end else begin
                if ($urandom_range(0, 59) == 0) x_pos = 10'($urandom);
                hh = m_x - 45 + int'($urandom_range(0, 170));
                vv = m_y - 10 + int'($urandom_range(0, 270));
                drive($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 7) != 0,
                      (hh % 1024 + 1024) % 1024, (vv % 1024 + 1024) % 1024,
                      $urandom_range(0, 63) == 0);
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fighter_sprite_renderer.md
# fighter_sprite_renderer

Parametrised, registered successor to the combinational character sprite generator. Draws one fighter per frame: stick figure, optional hurtbox outline and state-coloured attack hitbox, with facing-direction mirroring and a frame-counted hit-flash. Pose inputs are latched once per frame to prevent mid-frame tearing, and pixel outputs are registered. Sits between the game-logic FSM and the VGA colour mux, one instance per player.

## Interface
- WIDTH, 64: hurtbox width in pixels.
- HEIGHT, 240: hurtbox height in pixels.
- BORDER, 2: hurtbox outline thickness.
- HIT_W, 32: hitbox horizontal extent beyond the hurtbox.
- HIT_Y0, 80: hitbox top offset from y_pos.
- HIT_H, 80: hitbox height.
- FLASH_FRAMES, 8: frames of hit-flash after a hit (1..255).

- clk  in  1  pixel-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_tick  in  1  pixel enable; all state advances only when high.
- frame_start  in  1  one-tick pulse, first pixel of vertical blank.
- video_on  in  1  active-area flag from vga_background.
- hcnt, vcnt  in  10 each  pixel counters from vga_sync.
- x_pos, y_pos  in  10 each  hurtbox top-left.
- facing_left  in  1  1 = hitbox drawn on left side.
- attacking  in  1  active attack frames.
- state  in  3  fighter FSM state, selects hitbox colour.
- switch  in  1  1 = draw hurtbox outline.
- hit_taken  in  1  one-tick pulse when fighter is struck.
- sprite_on  out  1  registered; pixel belongs to this sprite.
- hitbox_on  out  1  registered; pixel is inside the drawn active hitbox.
- r, g, b  out  4 each  registered colour, 0 when sprite_on = 0.

## Operation
- Shadow registers (x, y, facing, attacking, state): load on pix_tick && frame_start. All geometry uses shadow values only; mid-frame input changes do not appear until the next frame.
- All coordinate sums use 11-bit unsigned arithmetic; no 10-bit wrap.
- Hurtbox: x ≤ h < x+WIDTH, y ≤ v < y+HEIGHT. Outline: any hurtbox pixel within BORDER of an edge.
- Hitbox vertical span: y+HIT_Y0 ≤ v < y+HIT_Y0+HIT_H.
- Hitbox horizontal span, facing right: x+WIDTH ≤ h < x+WIDTH+HIT_W.
- Hitbox horizontal span, facing left: x−HIT_W ≤ h < x. Computed as h+HIT_W ≥ x, so it clips at column 0 when x < HIT_W.
- Stick figure, relative coords rx = h−x, ry = v−y:
  - Head: disc, centre (WIDTH/2, 40), r² < 400.
  - Body: |rx−WIDTH/2| ≤ 2, 60 ≤ ry ≤ 120.
  - Arms: ry 80..120, slope 1/2, 4 px thick.
  - Legs: ry 120..180, slope 1/3, 4 px thick.
  - Mirrored about WIDTH/2 when facing = 1 (symmetric pose; a required hook for asymmetric poses).
- Draw conditions: figure only inside the hurtbox; hitbox only when attacking; outline only when switch.
- Colour priority: hitbox > outline > figure.
  - Hitbox colour by state: 4 = 0F0, 5 = 00F, 6 = F80, other = 0F0.
  - Outline: F00.
  - Figure: 00F, or FFF while flash_white.
- Hit-flash counter (8 bit):
  - hit_taken loads FLASH_FRAMES, including mid-flash restart.
  - Otherwise decrements on frame_start while nonzero.
  - flash_white = (cnt ≠ 0) && cnt[0].
  - Simultaneous hit_taken and frame_start: load wins, no decrement.

## Timing
- Latency: one pix_tick. Outputs for (hcnt, vcnt) appear on the clock edge that samples them with pix_tick = 1.
- Outputs hold when pix_tick = 0.
- Reset (async assert, sync-to-clk release): sprite_on, hitbox_on, r, g, b = 0; all shadow registers = 0; flash counter = 0.
- Reset mid-frame: outputs 0 until the next pixel tick after release; the pose stays 0 until the next frame_start.
- frame_start with pix_tick = 0 is ignored.

## Configuration
- SPRITE_FLASH_EN defined: flash counter and white figure are present as above.
- SPRITE_FLASH_EN undefined: counter is not built, hit_taken is ignored, and the figure is always 00F.

## Test plan
- Reset: rst_n = 0 mid-frame → all outputs 0 immediately; after release, pose = 0 until frame_start.
- Pose latch: x_pos = 100, y_pos = 50, frame_start, then x_pos changes to 300 mid-frame → pixel (132, 40+50) is head 00F, and column 300 stays blank for the whole frame.
- Facing right, attacking = 1, state = 6, x = 100, y = 50 → pixel (170, 170) is F80 with hitbox_on = 1, one tick after input.
- Facing left, x = 10, attacking = 1 → hitbox covers h 0..9 only and nothing appears at h ≥ 1000.
- switch = 1 plus attacking → hitbox colour overrides the outline in overlap; outline F00 at (100, 100), figure still drawn.
- SPRITE_FLASH_EN defined, FLASH_FRAMES = 3, hit_taken → figure FFF, 00F, FFF over 3 frames, then 00F. A second hit_taken coincident with frame_start → counter = 3.
